// File: rtl/cnn_stream_pkg.sv
// Shared types and helpers for the CNN pixel-stream blocks.
//   stream_mark_t : row/frame framing markers that travel alongside a sample
//   ram_style()   : picks a memory implementation from the storage depth
package cnn_stream_pkg;

  typedef struct packed {
    logic sop;
    logic eop;
    logic sof;
    logic eof;
  } stream_mark_t;

  // Small buffers are cheaper as fabric registers than as a block RAM.
  function automatic string ram_style(input int depth);
    return (depth < 32) ? "logic" : "M10K";
  endfunction

endpackage

// File: rtl/upsample_nn_ram.sv
// Simple dual-port RAM with synchronous read, holding two line-buffer banks.
// The address MSB selects the bank, the lower bits are the word offset
// inside the bank, so storage stays exactly 2*ROW_WORDS deep.
// Ports:
//   clk        clock
//   wr_en_i    write strobe, wr_addr_i / wr_data_i sampled on the edge
//   rd_en_i    read strobe, rd_data_o valid one cycle later
module upsample_nn_ram #(
  parameter int    DATA_WIDTH = 8,
  parameter int    ROW_WORDS  = 12,
  parameter int    OFS_W      = 4,
  parameter string RAM_STYLE  = "logic"
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [OFS_W:0]        wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [OFS_W:0]        rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int DEPTH = 2 * ROW_WORDS;
  localparam int IW    = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] rd_data_q;

  // Bank 1 starts right after bank 0, so the array has no unused holes.
  function automatic logic [IW-1:0] flat_index(input logic [OFS_W:0] addr);
    if (addr[OFS_W]) return IW'(ROW_WORDS) + IW'(addr[OFS_W-1:0]);
    return IW'(addr[OFS_W-1:0]);
  endfunction

  if (RAM_STYLE == "M10K") begin : g_block_ram
    (* ramstyle = "M10K" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (wr_en_i) mem[flat_index(wr_addr_i)] <= wr_data_i;
      if (rd_en_i) rd_data_q <= mem[flat_index(rd_addr_i)];
    end
  end else begin : g_logic_ram
    (* ramstyle = "logic" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (wr_en_i) mem[flat_index(wr_addr_i)] <= wr_data_i;
      if (rd_en_i) rd_data_q <= mem[flat_index(rd_addr_i)];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/upsample_nn.sv
// Nearest-neighbour upsampler for the decoder path (inverse of max-pool).
// Each input row is captured into one bank of a ping-pong line buffer and then
// replayed: every pixel (all channels) SCALE times horizontally, the whole
// widened row SCALE times vertically.
// Ports:
//   clk, reset                       clock, async active-high reset
//   valid_i/data_i/sop_i..eof_i      channel-interleaved input stream
//   ready_o                          input accepted when valid_i && ready_o
//   data_valid_o/data_o/sop_o..eof_o upsampled output stream, never stalled
//   err_o                            sticky framing error
module upsample_nn
  import cnn_stream_pkg::*;
#(
  parameter int    DATA_WIDTH  = 8,
  parameter int    CHANNEL_NUM = 3,
  parameter int    IN_WIDTH    = 4,
  parameter int    IN_HEIGHT   = 4,
  parameter int    SCALE       = 2,
  parameter string RAM_STYLE   = ram_style(CHANNEL_NUM * IN_WIDTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_i,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic                         sop_i,
  input  logic                         eop_i,
  input  logic                         sof_i,
  input  logic                         eof_i,
  output logic                         ready_o,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         data_valid_o,
  output logic                         sop_o,
  output logic                         eop_o,
  output logic                         sof_o,
  output logic                         eof_o,
  output logic                         err_o
);

  localparam int ROW_WORDS = IN_WIDTH * CHANNEL_NUM;
  localparam int OFS_W     = $clog2(ROW_WORDS);
  localparam int WCNT_W    = $clog2(ROW_WORDS) + 1;
  localparam int CH_W      = $clog2(CHANNEL_NUM) + 1;
  localparam int PIX_W     = $clog2(IN_WIDTH) + 1;
  localparam int REP_W     = $clog2(SCALE) + 1;
  localparam int ROW_W     = $clog2(IN_HEIGHT) + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PLAY = 1'b1;

  // Writer state
  logic [WCNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic              wr_bank_q, wr_bank_d;
  logic [1:0]        full_q, full_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              sof_seen_q, sof_seen_d;

  // Reader state
  logic [0:0]        state_q, state_d;
  logic              rd_bank_q, rd_bank_d;
  logic [CH_W-1:0]   chan_q, chan_d;
  logic [REP_W-1:0]  col_rep_q, col_rep_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [REP_W-1:0]  row_rep_q, row_rep_d;
  logic [ROW_W-1:0]  in_row_q, in_row_d;

  // Output pipe: stage 1 waits for the RAM, stage 2 is the output register
  logic                  s1_valid_q, s1_valid_d;
  stream_mark_t          s1_mark_q, s1_mark_d;
  logic                  out_valid_q, out_valid_d;
  stream_mark_t          out_mark_q, out_mark_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic                  accept, wr_done, rd_issue, bank_done;
  logic                  sop_err, eop_err, eof_err, sof_err, row_last;
  logic [WCNT_W-1:0]     wr_ofs;
  logic [OFS_W-1:0]      rd_ofs;
  logic                  chan_last, col_last, pix_last, row_rep_last, in_row_last;
  logic                  row_first, row_end;
  stream_mark_t          mark_now;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  // Writer: a misplaced sop restarts the row so this word lands at offset 0.
  // A misplaced eop throws the partial row away.
  always_comb begin
    accept     = valid_i && ready_q;
    sop_err    = accept && sop_i && (wr_cnt_q != '0);
    wr_ofs     = sop_err ? '0 : wr_cnt_q;
    row_last   = (wr_ofs == WCNT_W'(ROW_WORDS - 1));
    eop_err    = accept && eop_i && !row_last;
    eof_err    = accept && eof_i && !eop_i;
    sof_err    = accept && !sof_seen_q && !sof_i;
    sof_seen_d = sof_seen_q | (accept && sof_i);
    err_d      = err_q | sop_err | eop_err | eof_err | sof_err;
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    wr_done    = 1'b0;
    if (accept) begin
      if (eop_err) begin
        wr_cnt_d = '0;
      end else if (row_last) begin
        wr_cnt_d  = '0;
        wr_done   = 1'b1;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_cnt_d = wr_ofs + 1'b1;
      end
    end
  end

  // Reader FSM and bank bookkeeping. The stay-in-PLAY decision looks at
  // full_d so a row finishing this very cycle is picked up without a gap.
  always_comb begin
    rd_issue     = (state_q == S_PLAY);
    chan_last    = (chan_q == CH_W'(CHANNEL_NUM - 1));
    col_last     = (col_rep_q == REP_W'(SCALE - 1));
    pix_last     = (pix_q == PIX_W'(IN_WIDTH - 1));
    row_rep_last = (row_rep_q == REP_W'(SCALE - 1));
    in_row_last  = (in_row_q == ROW_W'(IN_HEIGHT - 1));
    row_first    = (chan_q == '0) && (col_rep_q == '0) && (pix_q == '0);
    row_end      = chan_last && col_last && pix_last;
    bank_done    = rd_issue && row_end && row_rep_last;
    rd_ofs       = OFS_W'(int'(pix_q) * CHANNEL_NUM + int'(chan_q));

    mark_now.sop = rd_issue && row_first;
    mark_now.eop = rd_issue && row_end;
    mark_now.sof = rd_issue && row_first && (row_rep_q == '0) && (in_row_q == '0);
    mark_now.eof = rd_issue && row_end && row_rep_last && in_row_last;

    full_d = full_q;
    if (wr_done)   full_d[wr_bank_q] = 1'b1;
    if (bank_done) full_d[rd_bank_q] = 1'b0;

    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    chan_d    = chan_q;
    col_rep_d = col_rep_q;
    pix_d     = pix_q;
    row_rep_d = row_rep_q;
    in_row_d  = in_row_q;

    case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) state_d = S_PLAY;
      end
      default: begin
        if (!chan_last) begin
          chan_d = chan_q + 1'b1;
        end else begin
          chan_d = '0;
          if (!col_last) begin
            col_rep_d = col_rep_q + 1'b1;
          end else begin
            col_rep_d = '0;
            if (!pix_last) begin
              pix_d = pix_q + 1'b1;
            end else begin
              pix_d = '0;
              if (!row_rep_last) begin
                row_rep_d = row_rep_q + 1'b1;
              end else begin
                row_rep_d = '0;
                rd_bank_d = ~rd_bank_q;
                in_row_d  = in_row_last ? '0 : in_row_q + 1'b1;
                if (!full_d[~rd_bank_q]) state_d = S_IDLE;
              end
            end
          end
        end
      end
    endcase

    ready_d = !full_d[wr_bank_d];
  end

  // Output pipe: markers ride along with the read so they meet the RAM data.
  always_comb begin
    s1_valid_d  = rd_issue;
    s1_mark_d   = mark_now;
    out_valid_d = s1_valid_q;
    out_mark_d  = s1_mark_q;
    out_data_d  = s1_valid_q ? ram_rd_data : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      full_q      <= '0;
      ready_q     <= 1'b1;
      err_q       <= 1'b0;
      sof_seen_q  <= 1'b0;
      state_q     <= S_IDLE;
      rd_bank_q   <= 1'b0;
      chan_q      <= '0;
      col_rep_q   <= '0;
      pix_q       <= '0;
      row_rep_q   <= '0;
      in_row_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_mark_q   <= '0;
      out_valid_q <= 1'b0;
      out_mark_q  <= '0;
      out_data_q  <= '0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      full_q      <= full_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      sof_seen_q  <= sof_seen_d;
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      chan_q      <= chan_d;
      col_rep_q   <= col_rep_d;
      pix_q       <= pix_d;
      row_rep_q   <= row_rep_d;
      in_row_q    <= in_row_d;
      s1_valid_q  <= s1_valid_d;
      s1_mark_q   <= s1_mark_d;
      out_valid_q <= out_valid_d;
      out_mark_q  <= out_mark_d;
      out_data_q  <= out_data_d;
    end
  end

  upsample_nn_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ROW_WORDS (ROW_WORDS),
    .OFS_W     (OFS_W),
    .RAM_STYLE (RAM_STYLE)
  ) u_ram (
    .clk      (clk),
    .wr_en_i  (accept),
    .wr_addr_i({wr_bank_q, OFS_W'(wr_ofs)}),
    .wr_data_i(data_i),
    .rd_en_i  (rd_issue),
    .rd_addr_i({rd_bank_q, rd_ofs}),
    .rd_data_o(ram_rd_data)
  );

  assign ready_o      = ready_q;
  assign err_o        = err_q;
  assign data_o       = out_data_q;
  assign data_valid_o = out_valid_q;
  assign sop_o        = out_mark_q.sop;
  assign eop_o        = out_mark_q.eop;
  assign sof_o        = out_mark_q.sof;
  assign eof_o        = out_mark_q.eof;

endmodule

// File: tb/tb_upsample_nn.sv
// Directed bench for upsample_nn. dut_a: CHANNEL_NUM=2, IN_WIDTH=2,
// IN_HEIGHT=2, SCALE=2. dut_b: CHANNEL_NUM=1, IN_WIDTH=2, SCALE=3.
// Both share the input stream; each test picks whose ready/outputs matter.
module tb_upsample_nn;

  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, valid_i, sop_i, eop_i, sof_i, eof_i;
  logic [DW-1:0] data_i;

  logic          ready_a, valid_a, sop_a, eop_a, sof_a, eof_a, err_a;
  logic [DW-1:0] data_a;
  logic          ready_b, valid_b, sop_b, eop_b, sof_b, eof_b, err_b;
  logic [DW-1:0] data_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  logic [DW-1:0] a_data[$], b_data[$], exp_data[$], in_words[$];
  logic [3:0]    a_mark[$], b_mark[$], exp_mark[$];
  int            a_stamp[$];

  upsample_nn #(.DATA_WIDTH(DW), .CHANNEL_NUM(2), .IN_WIDTH(2), .IN_HEIGHT(2), .SCALE(2)) dut_a (
    .clk(clk), .reset(reset), .valid_i(valid_i), .data_i(data_i),
    .sop_i(sop_i), .eop_i(eop_i), .sof_i(sof_i), .eof_i(eof_i),
    .ready_o(ready_a), .data_o(data_a), .data_valid_o(valid_a),
    .sop_o(sop_a), .eop_o(eop_a), .sof_o(sof_a), .eof_o(eof_a), .err_o(err_a)
  );

  upsample_nn #(.DATA_WIDTH(DW), .CHANNEL_NUM(1), .IN_WIDTH(2), .IN_HEIGHT(2), .SCALE(3)) dut_b (
    .clk(clk), .reset(reset), .valid_i(valid_i), .data_i(data_i),
    .sop_i(sop_i), .eop_i(eop_i), .sof_i(sof_i), .eof_i(eof_i),
    .ready_o(ready_b), .data_o(data_b), .data_valid_o(valid_b),
    .sop_o(sop_b), .eop_o(eop_b), .sof_o(sof_b), .eof_o(eof_b), .err_o(err_b)
  );

  // Capture every valid output word on the falling edge, with a cycle stamp.
  always @(negedge clk) begin
    cycle++;
    if (valid_a) begin
      a_data.push_back(data_a);
      a_mark.push_back({sop_a, eop_a, sof_a, eof_a});
      a_stamp.push_back(cycle);
    end
    if (valid_b) begin
      b_data.push_back(data_b);
      b_mark.push_back({sop_b, eop_b, sof_b, eof_b});
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Present one word and hold it until the selected DUT takes it.
  task automatic applyStimulus(input bit sel, input logic [DW-1:0] d,
                               input logic sop, input logic eop, input logic sof, input logic eof);
    int guard;
    guard = 0;
    @(negedge clk);
    valid_i = 1'b1; data_i = d; sop_i = sop; eop_i = eop; sof_i = sof; eof_i = eof;
    while (((sel ? ready_b : ready_a) !== 1'b1) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("ready timeout", sel ? ready_b : ready_a, 1);
    @(posedge clk);
  endtask

  task automatic idleInput();
    @(negedge clk);
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
  endtask

  task automatic sendRow(input bit sel, input int base, input int nwords, input bit frame_first, input bit frame_last);
    for (int i = 0; i < nwords; i++)
      applyStimulus(sel, in_words[base + i], i == 0, i == nwords - 1,
                    frame_first && i == 0, frame_last && i == nwords - 1);
  endtask

  task automatic clearQueues();
    a_data.delete(); a_mark.delete(); a_stamp.delete();
    b_data.delete(); b_mark.delete();
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b1;
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clearQueues();
  endtask

  // Reference: expected output words and markers for everything in in_words.
  task automatic buildExpected(input int c, input int w, input int h, input int s);
    int  nrows;
    logic first, last;
    exp_data.delete(); exp_mark.delete();
    nrows = in_words.size() / (c * w);
    for (int r = 0; r < nrows; r++)
      for (int rr = 0; rr < s; rr++)
        for (int p = 0; p < w; p++)
          for (int cr = 0; cr < s; cr++)
            for (int ch = 0; ch < c; ch++) begin
              first = (p == 0) && (cr == 0) && (ch == 0);
              last  = (p == w - 1) && (cr == s - 1) && (ch == c - 1);
              exp_data.push_back(in_words[r * c * w + p * c + ch]);
              exp_mark.push_back({first, last,
                                  first && rr == 0 && (r % h) == 0,
                                  last && rr == s - 1 && (r % h) == h - 1});
            end
  endtask

  task automatic compareStream(input string tag, input bit sel);
    int n;
    n = sel ? b_data.size() : a_data.size();
    checkOutput({tag, " count"}, n, exp_data.size());
    for (int i = 0; i < n && i < exp_data.size(); i++) begin
      checkOutput($sformatf("%s data[%0d]", tag, i), sel ? b_data[i] : a_data[i], exp_data[i]);
      checkOutput($sformatf("%s mark[%0d]", tag, i), sel ? b_mark[i] : a_mark[i], exp_mark[i]);
    end
  endtask

  function automatic int countMark(input int bit_idx);
    int n;
    n = 0;
    foreach (a_mark[i]) n += int'(a_mark[i][bit_idx]);
    return n;
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " outs a"}, {valid_a, sop_a, eop_a, sof_a, eof_a, err_a, data_a}, 0);
    checkOutput({tag, " ready a"}, ready_a, 1);
    checkOutput({tag, " outs b"}, {valid_b, sop_b, eop_b, sof_b, eof_b, err_b, data_b}, 0);
    checkOutput({tag, " ready b"}, ready_b, 1);
  endtask

  task automatic sendFrame();
    in_words = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    sendRow(0, 0, 4, 1, 0);
    sendRow(0, 4, 4, 0, 1);
    idleInput();
    repeat (60) @(negedge clk);
  endtask

  logic [DW-1:0] row1_tab[8];
  logic [DW-1:0] t6_tab[6];

  initial begin
    reset = 1'b1;
    valid_i = 1'b0; data_i = '0; sop_i = 1'b0; eop_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
    row1_tab = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd4};
    t6_tab   = '{8'd9, 8'd9, 8'd9, 8'hFB, 8'hFB, 8'hFB};

    @(negedge clk);
    checkResetOutputs("reset");
    reset = 1'b0;
    clearQueues();

    // Test 1: single row replay
    $display("[TB] test 1: single row");
    in_words = '{8'd1, 8'd2, 8'd3, 8'd4};
    sendRow(0, 0, 4, 1, 0);
    idleInput();
    repeat (40) @(negedge clk);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("t1 hand[%0d]", i), a_data[i], row1_tab[i % 8]);
    checkOutput("t1 sop first", a_mark[0][3], 1);
    checkOutput("t1 sop second", a_mark[8][3], 1);
    checkOutput("t1 eop first", a_mark[7][2], 1);
    checkOutput("t1 eop second", a_mark[15][2], 1);
    buildExpected(2, 2, 2, 2);
    compareStream("t1", 0);
    checkOutput("t1 err", err_a, 0);

    // Test 2: full frame
    $display("[TB] test 2: full frame");
    resetDut();
    sendFrame();
    buildExpected(2, 2, 2, 2);
    compareStream("t2", 0);
    checkOutput("t2 sop count", countMark(3), 4);
    checkOutput("t2 eop count", countMark(2), 4);
    checkOutput("t2 sof count", countMark(1), 1);
    checkOutput("t2 eof count", countMark(0), 1);
    checkOutput("t2 sof at 0", a_mark[0][1], 1);
    checkOutput("t2 eof at 31", a_mark[31][0], 1);

    // Test 3: back-to-back rows, backpressure and gapless bank switch
    $display("[TB] test 3: backpressure");
    resetDut();
    in_words = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12};
    sendRow(0, 0, 4, 1, 0);
    sendRow(0, 4, 4, 0, 1);
    @(negedge clk);
    checkOutput("t3 ready low", ready_a, 0);
    sendRow(0, 8, 4, 1, 0);
    idleInput();
    repeat (80) @(negedge clk);
    buildExpected(2, 2, 2, 2);
    compareStream("t3", 0);
    for (int i = 1; i < a_stamp.size(); i++)
      checkOutput($sformatf("t3 gap[%0d]", i), a_stamp[i] - a_stamp[i - 1], 1);

    // Test 4: framing errors
    $display("[TB] test 4: framing errors");
    resetDut();
    applyStimulus(0, 8'd1, 1, 0, 1, 0);
    #1 checkOutput("t4 err before", err_a, 0);
    applyStimulus(0, 8'd2, 1, 0, 0, 0);
    #1 checkOutput("t4 err after sop", err_a, 1);
    applyStimulus(0, 8'd3, 0, 0, 0, 0);
    applyStimulus(0, 8'd4, 0, 0, 0, 0);
    applyStimulus(0, 8'd5, 0, 1, 0, 0);
    idleInput();
    repeat (40) @(negedge clk);
    checkOutput("t4 err sticky", err_a, 1);
    in_words = '{8'd2, 8'd3, 8'd4, 8'd5};
    buildExpected(2, 2, 2, 2);
    compareStream("t4", 0);

    resetDut();
    applyStimulus(0, 8'd7, 1, 0, 1, 1);
    #1 checkOutput("t4 eof without eop", err_a, 1);
    resetDut();
    applyStimulus(0, 8'd7, 1, 1, 1, 0);
    #1 checkOutput("t4 early eop", err_a, 1);
    resetDut();
    applyStimulus(0, 8'd7, 1, 0, 0, 0);
    #1 checkOutput("t4 missing sof", err_a, 1);
    idleInput();

    // Test 5: reset during replay, then a clean frame
    $display("[TB] test 5: reset mid-replay");
    resetDut();
    in_words = '{8'd1, 8'd2, 8'd3, 8'd4};
    sendRow(0, 0, 4, 1, 0);
    idleInput();
    repeat (10) @(negedge clk);
    checkOutput("t5 busy", valid_a, 1);
    reset = 1'b1;
    #1 checkResetOutputs("t5 reset");
    @(negedge clk);
    reset = 1'b0;
    clearQueues();
    sendFrame();
    buildExpected(2, 2, 2, 2);
    compareStream("t5", 0);

    // Test 6: SCALE=3, single channel, signed data
    $display("[TB] test 6: scale 3");
    resetDut();
    in_words = '{8'd9, 8'hFB};
    applyStimulus(1, 8'd9, 1, 0, 1, 0);
    applyStimulus(1, 8'hFB, 0, 1, 0, 0);
    idleInput();
    repeat (40) @(negedge clk);
    for (int i = 0; i < 18; i++)
      checkOutput($sformatf("t6 hand[%0d]", i), b_data[i], t6_tab[i % 6]);
    checkOutput("t6 sign", b_data[3][7], 1);
    buildExpected(1, 2, 2, 3);
    compareStream("t6", 1);
    checkOutput("t6 err", err_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
